// File: rtl/intra_loop_pkg.sv
// intra_loop_pkg: frame geometry, engine states and mbnumber field positions
package intra_loop_pkg;
    localparam int WIDTH = 1280;
    localparam int HEIGHT = 720;
    localparam int AW = 20;
    localparam int Y_MSB = 31;
    localparam int Y_LSB = 16;
    localparam int X_MSB = 15;
    localparam int X_LSB = 0;
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, COMPUTE, WRITE, DONE} state_t;
endpackage

// File: rtl/intra_loop_dc_engine.sv
// intra_dc_engine: fetches neighbours of one NxN block, forms the DC value, writes the block back and pulses fb
module intra_dc_engine
    import intra_loop_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [31:0]   mbnumber,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          fb
);
    localparam int LN = $clog2(N);
    state_t state, state_n;
    logic [15:0] x, y, cap_x, cap_y;
    logic [7:0] cnt, n_rd, rd_k, dc, dc_full;
    logic [11:0] sum_t, sum_l;
    logic pend, pend_top, top_av, left_av, in_frame, rd_top;
    logic [AW-1:0] base;
    always_comb begin
        cap_x = mbnumber[X_MSB:X_LSB];
        cap_y = mbnumber[Y_MSB:Y_LSB];
        top_av = y != '0;
        left_av = x != '0;
        in_frame = 17'(x) + 17'(N) <= 17'(WIDTH) && 17'(y) + 17'(N) <= 17'(HEIGHT);
        n_rd = (top_av ? 8'(N) : 8'd0) + (left_av ? 8'(N) : 8'd0);
        rd_top = top_av && cnt < 8'(N);
        rd_k = rd_top || !top_av ? cnt : cnt - 8'(N);
        base = AW'(y) * AW'(WIDTH) + AW'(x);
        dc_full = top_av && left_av ? 8'((sum_t + sum_l + 12'(N)) >> (LN + 1))
                : top_av ? 8'((sum_t + 12'(N / 2)) >> LN)
                : left_av ? 8'((sum_l + 12'(N / 2)) >> LN) : 8'd128;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            x <= '0;
            y <= '0;
            cnt <= '0;
            sum_t <= '0;
            sum_l <= '0;
            pend <= 1'b0;
            pend_top <= 1'b0;
            dc <= '0;
        end else begin
            state <= state_n;
            cnt <= state_n != state ? '0 : cnt + 8'd1;
            // read data lands one cycle after its address, so tag it for the following edge
            pend <= state == FETCH;
            pend_top <= rd_top;
            if (state == IDLE) begin
                x <= cap_x;
                y <= cap_y;
                sum_t <= '0;
                sum_l <= '0;
            end
            if (pend && pend_top) sum_t <= sum_t + 12'(rd_data);
            if (pend && !pend_top) sum_l <= sum_l + 12'(rd_data);
            if (state == COMPUTE) dc <= dc_full;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !enable ? IDLE : (cap_x != '0 || cap_y != '0) ? FETCH : COMPUTE;
            FETCH:   state_n = cnt == n_rd - 8'd1 ? DRAIN : FETCH;
            DRAIN:   state_n = COMPUTE;
            COMPUTE: state_n = in_frame ? WRITE : DONE;
            WRITE:   state_n = cnt == 8'(N * N - 1) ? DONE : WRITE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        rd_addr = state != FETCH ? '0
                : rd_top ? base - AW'(WIDTH) + AW'(rd_k)
                : base + AW'(rd_k) * AW'(WIDTH) - AW'(1);
        wr_en = state == WRITE;
        wr_addr = wr_en ? base + AW'(cnt >> LN) * AW'(WIDTH) + AW'(cnt & 8'(N - 1)) : '0;
        wr_data = wr_en ? dc : '0;
        fb = state == DONE;
    end
endmodule

// File: rtl/intra_loop.sv
// intra_loop: luma 4x4, Cb 8x8 and Cr 8x8 DC reconstruction engines running side by side
module intra_loop
    import intra_loop_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [31:0]   mbnumber_luma4x4,
    input  logic [31:0]   mbnumber_chromab8x8,
    input  logic [31:0]   mbnumber_chromar8x8,
    output logic [AW-1:0] luma_rd_addr,
    input  logic [7:0]    luma_rd_data,
    output logic          luma_wr_en,
    output logic [AW-1:0] luma_wr_addr,
    output logic [7:0]    luma_wr_data,
    output logic [AW-1:0] chb_rd_addr,
    input  logic [7:0]    chb_rd_data,
    output logic          chb_wr_en,
    output logic [AW-1:0] chb_wr_addr,
    output logic [7:0]    chb_wr_data,
    output logic [AW-1:0] chr_rd_addr,
    input  logic [7:0]    chr_rd_data,
    output logic          chr_wr_en,
    output logic [AW-1:0] chr_wr_addr,
    output logic [7:0]    chr_wr_data,
    output logic          fb_luma4x4,
    output logic          fb_chromab8x8,
    output logic          fb_chromar8x8
);
    intra_dc_engine #(.N(4)) u_luma (
        .clk(clk), .reset(reset), .enable(enable), .mbnumber(mbnumber_luma4x4),
        .rd_addr(luma_rd_addr), .rd_data(luma_rd_data), .wr_en(luma_wr_en),
        .wr_addr(luma_wr_addr), .wr_data(luma_wr_data), .fb(fb_luma4x4)
    );
    intra_dc_engine #(.N(8)) u_chb (
        .clk(clk), .reset(reset), .enable(enable), .mbnumber(mbnumber_chromab8x8),
        .rd_addr(chb_rd_addr), .rd_data(chb_rd_data), .wr_en(chb_wr_en),
        .wr_addr(chb_wr_addr), .wr_data(chb_wr_data), .fb(fb_chromab8x8)
    );
    intra_dc_engine #(.N(8)) u_chr (
        .clk(clk), .reset(reset), .enable(enable), .mbnumber(mbnumber_chromar8x8),
        .rd_addr(chr_rd_addr), .rd_data(chr_rd_data), .wr_en(chr_wr_en),
        .wr_addr(chr_wr_addr), .wr_data(chr_wr_data), .fb(fb_chromar8x8)
    );
endmodule

// File: tb/tb_intra_loop.sv
// tb_intra_loop: table-driven and randomized checks of the three DC engines against frame-RAM models
module tb_intra_loop;
    import intra_loop_pkg::*;
    localparam int NPIX = WIDTH * HEIGHT;
    typedef struct {
        int ly, lx, ld, by, bx, bd, ry, rx, rd;
    } vec_t;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [31:0] mb [3];
    logic [AW-1:0] rd_addr [3], wr_addr [3];
    logic [7:0] rd_data [3], wr_data [3];
    logic wr_en [3], fb [3];
    logic [7:0] mem [3][NPIX];
    logic poke_en = 1'b0;
    int poke_p, poke_a;
    logic [7:0] poke_d;
    int checks = 0, errors = 0;
    string pname [3] = '{"luma", "cb", "cr"};

    always #5 clk = ~clk;

    intra_loop dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mbnumber_luma4x4(mb[0]), .mbnumber_chromab8x8(mb[1]), .mbnumber_chromar8x8(mb[2]),
        .luma_rd_addr(rd_addr[0]), .luma_rd_data(rd_data[0]), .luma_wr_en(wr_en[0]),
        .luma_wr_addr(wr_addr[0]), .luma_wr_data(wr_data[0]),
        .chb_rd_addr(rd_addr[1]), .chb_rd_data(rd_data[1]), .chb_wr_en(wr_en[1]),
        .chb_wr_addr(wr_addr[1]), .chb_wr_data(wr_data[1]),
        .chr_rd_addr(rd_addr[2]), .chr_rd_data(rd_data[2]), .chr_wr_en(wr_en[2]),
        .chr_wr_addr(wr_addr[2]), .chr_wr_data(wr_data[2]),
        .fb_luma4x4(fb[0]), .fb_chromab8x8(fb[1]), .fb_chromar8x8(fb[2])
    );

    // frame RAMs: 1-cycle read latency, DUT writes plus bench pokes
    always @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] <= int'(rd_addr[p]) < NPIX ? mem[p][rd_addr[p]] : 8'd0;
            if (wr_en[p] && int'(wr_addr[p]) < NPIX) mem[p][wr_addr[p]] <= wr_data[p];
        end
        if (poke_en) mem[poke_p][poke_a] <= poke_d;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic poke(input int p, input int a, input int d);
        poke_p = p;
        poke_a = a;
        poke_d = 8'(d);
        poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    function automatic int nsz(int p);
        return p == 0 ? 4 : 8;
    endfunction

    function automatic int peek(int p, int a);
        return a >= 0 && a < NPIX ? int'(mem[p][a]) : 0;
    endfunction

    function automatic int model_dc(int p, int y, int x);
        int n = nsz(p), st = 0, sl = 0;
        for (int i = 0; i < n; i++) begin
            st += peek(p, (y - 1) * WIDTH + x + i);
            sl += peek(p, (y + i) * WIDTH + x - 1);
        end
        if (y > 0 && x > 0) return (st + sl + n) / (2 * n);
        if (y > 0) return (st + n / 2) / n;
        if (x > 0) return (sl + n / 2) / n;
        return 128;
    endfunction

    function automatic int exp_rd(int p, int y, int x, int j);
        int n = nsz(p);
        if (y > 0 && j < n) return (y - 1) * WIDTH + x + j;
        return (y + j - (y > 0 ? n : 0)) * WIDTH + x - 1;
    endfunction

    // one block per engine, started together; caller is at a negedge, returns at a negedge
    task automatic run(input int py [3], input int px [3], output int obs [3]);
        int n [3], dcx [3], nr [3], nwx [3], fbx [3], fbn [3], fbc [3], nw [3], badw [3], badr [3];
        for (int p = 0; p < 3; p++) begin
            n[p] = nsz(p);
            dcx[p] = model_dc(p, py[p], px[p]);
            nr[p] = (py[p] > 0 ? n[p] : 0) + (px[p] > 0 ? n[p] : 0);
            nwx[p] = (px[p] + n[p] <= WIDTH && py[p] + n[p] <= HEIGHT) ? n[p] * n[p] : 0;
            fbx[p] = (nr[p] > 0 ? nr[p] + 1 : 0) + 1 + nwx[p] + 1;
            fbn[p] = 0;
            fbc[p] = -1;
            nw[p] = 0;
            badw[p] = 0;
            badr[p] = 0;
            obs[p] = -1;
            mb[p] = {16'(py[p]), 16'(px[p])};
        end
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int p = 0; p < 3; p++) mb[p] = $urandom;
        for (int c = 1; c <= 90; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (c <= nr[p] && int'(rd_addr[p]) != exp_rd(p, py[p], px[p], c - 1)) badr[p]++;
                if (fb[p]) begin
                    fbn[p]++;
                    if (fbc[p] < 0) fbc[p] = c;
                end
                if (wr_en[p]) begin
                    if (nw[p] >= nwx[p] || int'(wr_data[p]) != dcx[p] ||
                        int'(wr_addr[p]) != (py[p] + nw[p] / n[p]) * WIDTH + px[p] + nw[p] % n[p]) badw[p]++;
                    if (obs[p] < 0) obs[p] = int'(wr_data[p]);
                    nw[p]++;
                end
            end
            @(negedge clk);
        end
        for (int p = 0; p < 3; p++) begin
            check($sformatf("%s(%0d,%0d) read addrs bad", pname[p], py[p], px[p]), badr[p], 0);
            check($sformatf("%s(%0d,%0d) fb count", pname[p], py[p], px[p]), fbn[p], 1);
            check($sformatf("%s(%0d,%0d) fb cycle", pname[p], py[p], px[p]), fbc[p], fbx[p]);
            check($sformatf("%s(%0d,%0d) write count", pname[p], py[p], px[p]), nw[p], nwx[p]);
            check($sformatf("%s(%0d,%0d) writes bad", pname[p], py[p], px[p]), badw[p], 0);
        end
    endtask

    initial begin
        vec_t tv [3];
        int py [3], px [3], obs [3], q [$], act;
        tv[0] = '{ly: 4, lx: 4, ld: 45, by: 0, bx: 8, bd: 200, ry: 16, rx: 0, rd: 5};
        tv[1] = '{ly: 0, lx: 0, ld: 128, by: 0, bx: 0, bd: 128, ry: 0, rx: 0, rd: 128};
        tv[2] = '{ly: 8, lx: 1278, ld: -1, by: 716, bx: 0, bd: -1, ry: 0, rx: 1276, rd: -1};
        for (int p = 0; p < 3; p++) mb[p] = '0;
        repeat (3) @(negedge clk);
        act = 0;
        for (int p = 0; p < 3; p++)
            act |= int'(rd_addr[p]) | int'(wr_addr[p]) | int'(wr_data[p]) | int'(wr_en[p]) | int'(fb[p]);
        check("outputs during reset", act, 0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            poke(0, 3 * WIDTH + 4 + i, 10 * (i + 1));
            poke(0, (4 + i) * WIDTH + 3, 50 + 10 * i);
        end
        for (int i = 0; i < 8; i++) begin
            poke(1, i * WIDTH + 7, 200);
            poke(2, 15 * WIDTH + i, i + 1);
        end
        foreach (tv[t]) begin
            py = '{tv[t].ly, tv[t].by, tv[t].ry};
            px = '{tv[t].lx, tv[t].bx, tv[t].rx};
            run(py, px, obs);
            check($sformatf("vec%0d luma dc", t), obs[0], tv[t].ld);
            check($sformatf("vec%0d cb dc", t), obs[1], tv[t].bd);
            check($sformatf("vec%0d cr dc", t), obs[2], tv[t].rd);
        end
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < 3; p++) begin
                px[p] = nsz(p) * int'($urandom_range(0, WIDTH / nsz(p) - 1));
                py[p] = nsz(p) * int'($urandom_range(0, HEIGHT / nsz(p) - 1));
                if ($urandom_range(0, 3) == 0) px[p] = 0;
                if ($urandom_range(0, 3) == 0) py[p] = 0;
                for (int i = 0; i < nsz(p); i++) begin
                    if (py[p] > 0) poke(p, (py[p] - 1) * WIDTH + px[p] + i, int'($urandom_range(0, 255)));
                    if (px[p] > 0) poke(p, (py[p] + i) * WIDTH + px[p] - 1, int'($urandom_range(0, 255)));
                end
            end
            run(py, px, obs);
        end
        mb[0] = '0;
        mb[1] = {16'd716, 16'd0};
        mb[2] = {16'd0, 16'd1276};
        enable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (fb[0]) q.push_back(c);
        end
        enable = 1'b0;
        check("held enable luma fb count", q.size(), 2);
        check("held enable first fb", q.size() > 0 ? q[0] : -1, 18);
        check("held enable second fb", q.size() > 1 ? q[1] : -1, 37);
        repeat (100) @(negedge clk);
        mb[0] = {16'd4, 16'd4};
        mb[1] = '0;
        mb[2] = '0;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (14) @(negedge clk);
        check("luma wr_en before reset", int'(wr_en[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        act = 0;
        for (int p = 0; p < 3; p++) act |= int'(wr_en[p]) | int'(fb[p]);
        check("wr_en/fb after mid-write reset", act, 0);
        reset = 1'b0;
        act = 0;
        repeat (60) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) act |= int'(wr_en[p]) | int'(fb[p]);
        end
        check("activity after reset", act, 0);
        mb[0] = {16'd8, 16'd8};
        mb[1] = {16'd8, 16'd8};
        mb[2] = {16'd8, 16'd8};
        act = 0;
        repeat (40) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) act |= int'(rd_addr[p]) | int'(wr_en[p]) | int'(fb[p]);
        end
        check("activity with enable low", act, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
